// File: rtl/mcpu_mem_ptw_arb.sv
// Round-robin arbiter that shares one page-table walker between the itlb and dtlb.
// A one-entry last-translation cache lets a repeated miss skip the walk.
module mcpu_mem_ptw_arb #(
    parameter bit RR_INIT  = 1'b0,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic         clkrst_mem_clk,
    input  logic         clkrst_mem_rst_n,
    input  logic         itlb2ptwa_valid,
    input  logic [31:12] itlb2ptwa_addr,
    output logic         itlb2ptwa_resp,
    input  logic         dtlb2ptwa_valid,
    input  logic [31:12] dtlb2ptwa_addr,
    output logic         dtlb2ptwa_resp,
    input  logic [19:0]  ptwa_pagedir_base,
    input  logic         ptwa_flush,
    output logic [31:12] ptwa_phys_addr,
    output logic [3:0]   ptwa_pagedir_flags,
    output logic [3:0]   ptwa_pagetab_flags,
    output logic         ptwa_fault,
    output logic [31:12] tlb2ptw_addr,
    output logic         tlb2ptw_re,
    output logic [19:0]  tlb2ptw_pagedir_base,
    input  logic [31:12] tlb2ptw_phys_addr,
    input  logic         tlb2ptw_ready,
    input  logic [3:0]   tlb2ptw_pagetab_flags,
    input  logic [3:0]   tlb2ptw_pagedir_flags
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WALK, S_RESP} state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;
    logic          sel_q, sel_d;
    logic [31:12]  addr_q, addr_d;
    logic [19:0]   base_q, base_d;
    logic          drop_q, drop_d;
    logic          cvalid_q, cvalid_d;
    logic [31:12]  ctag_addr_q, ctag_addr_d;
    logic [19:0]   ctag_base_q, ctag_base_d;
    logic [31:12]  cphys_q, cphys_d;
    logic [3:0]    cpd_q, cpd_d, cpt_q, cpt_d;
    logic [31:12]  phys_q, phys_d;
    logic [3:0]    pd_q, pd_d, pt_q, pt_d;
    logic          fault_q, fault_d;

    logic take, grant_sel, hit, walk_done;

    // Grant only while the walker is idle, so a walk abandoned by reset cannot collide.
    assign take      = (itlb2ptwa_valid | dtlb2ptwa_valid) & tlb2ptw_ready;
    assign grant_sel = (itlb2ptwa_valid & dtlb2ptwa_valid) ? prio_q : dtlb2ptwa_valid;
    assign hit       = CACHE_EN & cvalid_q & (ctag_addr_q == addr_q) &
                       (ctag_base_q == base_q) & ~ptwa_flush;
    assign walk_done = (state_q == S_WALK) & tlb2ptw_ready;

    always_ff @(posedge clkrst_mem_clk) begin
        if (!clkrst_mem_rst_n) state_q <= S_IDLE;
        else                   state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take) state_d = S_CHECK;
            S_CHECK: if (hit) state_d = S_RESP;
                     else if (tlb2ptw_ready) state_d = S_ISSUE;
            S_ISSUE: if (!tlb2ptw_ready) state_d = S_WALK;
            S_WALK:  if (tlb2ptw_ready) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        itlb2ptwa_resp = 1'b0;
        dtlb2ptwa_resp = 1'b0;
        tlb2ptw_re     = 1'b0;
        case (state_q)
            S_ISSUE: tlb2ptw_re = 1'b1;
            S_RESP: begin
                itlb2ptwa_resp = ~sel_q;
                dtlb2ptwa_resp = sel_q;
            end
            default: ;
        endcase
    end

    assign tlb2ptw_addr         = addr_q;
    assign tlb2ptw_pagedir_base = base_q;
    assign ptwa_phys_addr       = phys_q;
    assign ptwa_pagedir_flags   = pd_q;
    assign ptwa_pagetab_flags   = pt_q;
    assign ptwa_fault           = fault_q;

    always_comb begin
        prio_d      = prio_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        base_d      = base_q;
        drop_d      = drop_q | ptwa_flush;
        cvalid_d    = cvalid_q;
        ctag_addr_d = ctag_addr_q;
        ctag_base_d = ctag_base_q;
        cphys_d     = cphys_q;
        cpd_d       = cpd_q;
        cpt_d       = cpt_q;
        phys_d      = phys_q;
        pd_d        = pd_q;
        pt_d        = pt_q;
        fault_d     = fault_q;

        if (state_q == S_IDLE) begin
            drop_d = ptwa_flush;
            if (take) begin
                sel_d  = grant_sel;
                prio_d = ~grant_sel;
                addr_d = grant_sel ? dtlb2ptwa_addr : itlb2ptwa_addr;
                base_d = ptwa_pagedir_base;
            end
        end

        if (state_q == S_CHECK && hit) begin
            phys_d  = cphys_q;
            pd_d    = cpd_q;
            pt_d    = cpt_q;
            fault_d = ~cpd_q[0] | ~cpt_q[0];
        end

        if (walk_done) begin
            phys_d  = tlb2ptw_phys_addr;
            pd_d    = tlb2ptw_pagedir_flags;
            pt_d    = tlb2ptw_pagetab_flags;
            fault_d = ~tlb2ptw_pagedir_flags[0] | ~tlb2ptw_pagetab_flags[0];
            // A flush at any point since the grant may have made this result stale.
            if (!drop_q && !ptwa_flush) begin
                cvalid_d    = 1'b1;
                ctag_addr_d = addr_q;
                ctag_base_d = base_q;
                cphys_d     = tlb2ptw_phys_addr;
                cpd_d       = tlb2ptw_pagedir_flags;
                cpt_d       = tlb2ptw_pagetab_flags;
            end
        end

        if (ptwa_flush) cvalid_d = 1'b0;
    end

    always_ff @(posedge clkrst_mem_clk) begin
        if (!clkrst_mem_rst_n) begin
            prio_q      <= RR_INIT;
            sel_q       <= 1'b0;
            addr_q      <= '0;
            base_q      <= '0;
            drop_q      <= 1'b0;
            cvalid_q    <= 1'b0;
            ctag_addr_q <= '0;
            ctag_base_q <= '0;
            cphys_q     <= '0;
            cpd_q       <= '0;
            cpt_q       <= '0;
            phys_q      <= '0;
            pd_q        <= '0;
            pt_q        <= '0;
            fault_q     <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            base_q      <= base_d;
            drop_q      <= drop_d;
            cvalid_q    <= cvalid_d;
            ctag_addr_q <= ctag_addr_d;
            ctag_base_q <= ctag_base_d;
            cphys_q     <= cphys_d;
            cpd_q       <= cpd_d;
            cpt_q       <= cpt_d;
            phys_q      <= phys_d;
            pd_q        <= pd_d;
            pt_q        <= pt_d;
            fault_q     <= fault_d;
        end
    end

endmodule

// File: tb/tb_mcpu_mem_ptw_arb.sv
// Scoreboard bench for mcpu_mem_ptw_arb: directed requests, a behavioural walker,
// and a monitor that pops expected responses whenever a resp pulse appears.
`timescale 1ns/1ps
module tb_mcpu_mem_ptw_arb;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         itlb_valid = 1'b0, dtlb_valid = 1'b0;
    logic [31:12] itlb_addr = '0, dtlb_addr = '0;
    logic         itlb_resp, dtlb_resp;
    logic [19:0]  pd_base = 20'h00100;
    logic         flush = 1'b0;
    logic [31:12] phys;
    logic [3:0]   pdf, ptf;
    logic         fault;
    logic [31:12] w_addr;
    logic         re;
    logic [19:0]  w_base;
    logic [31:12] w_phys_o = '0;
    logic         ready = 1'b1;
    logic [3:0]   w_pt_o = '0, w_pd_o = '0;

    always #5 clk = ~clk;

    mcpu_mem_ptw_arb dut (
        .clkrst_mem_clk(clk), .clkrst_mem_rst_n(rst_n),
        .itlb2ptwa_valid(itlb_valid), .itlb2ptwa_addr(itlb_addr), .itlb2ptwa_resp(itlb_resp),
        .dtlb2ptwa_valid(dtlb_valid), .dtlb2ptwa_addr(dtlb_addr), .dtlb2ptwa_resp(dtlb_resp),
        .ptwa_pagedir_base(pd_base), .ptwa_flush(flush),
        .ptwa_phys_addr(phys), .ptwa_pagedir_flags(pdf), .ptwa_pagetab_flags(ptf),
        .ptwa_fault(fault),
        .tlb2ptw_addr(w_addr), .tlb2ptw_re(re), .tlb2ptw_pagedir_base(w_base),
        .tlb2ptw_phys_addr(w_phys_o), .tlb2ptw_ready(ready),
        .tlb2ptw_pagetab_flags(w_pt_o), .tlb2ptw_pagedir_flags(w_pd_o)
    );

    typedef struct {
        logic        sel;
        logic [19:0] phys;
        logic [3:0]  pd;
        logic [3:0]  pt;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int resp_cnt = 0, i_cnt = 0, d_cnt = 0, walk_cnt = 0, re_cyc = 0;
    int last_resp_cyc = 0, rise_cyc = 0;
    logic re_prev = 1'b0;

    // Walker model: result values, stall before accepting, busy latency.
    logic [19:0] w_phys = '0;
    logic [3:0]  w_pd = '0, w_pt = '0;
    int stall_left = 0, w_lat = 4, w_cnt = 0;
    bit flush_arm = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic s, input logic [19:0] p, input logic [3:0] pd, input logic [3:0] pt);
        exp_t e;
        e.sel = s; e.phys = p; e.pd = pd; e.pt = pt; e.fault = ~pd[0] | ~pt[0];
        sb.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ready) begin
            if (re) begin
                if (stall_left > 0) stall_left = stall_left - 1;
                else begin
                    ready = 1'b0;
                    w_cnt = w_lat;
                end
            end
        end else begin
            chk("re_while_walker_busy", 32'(re), 32'd0);
            w_cnt = w_cnt - 1;
            if (w_cnt <= 0) begin
                ready    = 1'b1;
                w_phys_o = w_phys;
                w_pd_o   = w_pd;
                w_pt_o   = w_pt;
                rise_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (flush_arm && !ready) begin
            flush = 1'b1;
            flush_arm = 0;
            @(negedge clk);
            flush = 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (re && !re_prev) walk_cnt++;
        if (re) re_cyc++;
        re_prev = re;
        if (itlb_resp || dtlb_resp) begin
            if (itlb_resp && dtlb_resp) chk("resp_onehot", 32'd2, 32'd1);
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_resp: got itlb=%0b dtlb=%0b expected none (cycle %0d)",
                         itlb_resp, dtlb_resp, cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_sel", 32'(dtlb_resp), 32'(e.sel));
                chk("phys", 32'(phys), 32'(e.phys));
                chk("pd_flags", 32'(pdf), 32'(e.pd));
                chk("pt_flags", 32'(ptf), 32'(e.pt));
                chk("fault", 32'(fault), 32'(e.fault));
            end
            resp_cnt++;
            if (itlb_resp) i_cnt++;
            if (dtlb_resp) d_cnt++;
            last_resp_cyc = cyc;
        end
    end

    task automatic req(input logic s, input logic [19:0] a, input int exp_walks, input bit is_hit);
        int r0, w0, c0;
        bit done;
        done = 0;
        @(negedge clk);
        r0 = resp_cnt; w0 = walk_cnt; c0 = cyc;
        if (s) begin dtlb_valid = 1'b1; dtlb_addr = a; end
        else   begin itlb_valid = 1'b1; itlb_addr = a; end
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk); #1;
            if (resp_cnt != r0) done = 1;
        end
        itlb_valid = 1'b0;
        dtlb_valid = 1'b0;
        if (!done) chk("req_timeout", 32'd1, 32'd0);
        chk("walk_count", 32'(walk_cnt - w0), 32'(exp_walks));
        if (is_hit) chk("hit_latency", 32'(last_resp_cyc - c0), 32'd2);
        else if (exp_walks > 0) chk("miss_latency", 32'(last_resp_cyc - rise_cyc), 32'd1);
    endtask

    task automatic both_req(input int n);
        int r0, w0, i0, d0;
        bit done;
        done = 0;
        for (int i = 0; i < n; i++) push(logic'(i % 2), 20'h55555, 4'h1, 4'h1);
        @(negedge clk);
        r0 = resp_cnt; w0 = walk_cnt; i0 = i_cnt; d0 = d_cnt;
        itlb_valid = 1'b1; itlb_addr = 20'h00001;
        dtlb_valid = 1'b1; dtlb_addr = 20'h00002;
        for (int k = 0; k < 100 * n && !done; k++) begin
            @(negedge clk); #1;
            if (resp_cnt - r0 >= n) done = 1;
        end
        itlb_valid = 1'b0;
        dtlb_valid = 1'b0;
        if (!done) chk("both_timeout", 32'd1, 32'd0);
        chk("both_walks", 32'(walk_cnt - w0), 32'(n));
        chk("itlb_served", 32'(i_cnt - i0), 32'(n / 2));
        chk("dtlb_served", 32'(d_cnt - d0), 32'(n / 2));
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        int r0;
        bit busy_seen;
        repeat (3) @(negedge clk);
        chk("rst_itlb_resp", 32'(itlb_resp), 32'd0);
        chk("rst_dtlb_resp", 32'(dtlb_resp), 32'd0);
        chk("rst_re", 32'(re), 32'd0);
        chk("rst_phys", 32'(phys), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        rst_n = 1'b1;

        // First itlb miss, then the same page hits the cache.
        w_phys = 20'hABCDE; w_pd = 4'h1; w_pt = 4'h3;
        re_cyc = 0;
        push(1'b0, 20'hABCDE, 4'h1, 4'h3);
        req(1'b0, 20'h12345, 1, 0);
        chk("re_cycles_miss", 32'(re_cyc), 32'd1);
        push(1'b0, 20'hABCDE, 4'h1, 4'h3);
        req(1'b0, 20'h12345, 0, 1);
        repeat (3) @(negedge clk);
        chk("result_hold", 32'(phys), 32'hABCDE);

        // Round robin from reset priority, then 8 back-to-back with both held.
        do_reset();
        w_phys = 20'h55555; w_pd = 4'h1; w_pt = 4'h1;
        both_req(2);
        both_req(8);

        // Walker stalls with ready high for 5 cycles while re is asserted.
        w_phys = 20'h13579;
        stall_left = 5;
        re_cyc = 0;
        push(1'b1, 20'h13579, 4'h1, 4'h1);
        req(1'b1, 20'h0AAAA, 1, 0);
        chk("re_cycles_stall", 32'(re_cyc), 32'd6);

        // Flush during the walk: result delivered but not cached.
        w_phys = 20'h2468A;
        flush_arm = 1;
        push(1'b0, 20'h2468A, 4'h1, 4'h1);
        req(1'b0, 20'h0BBBB, 1, 0);
        push(1'b0, 20'h2468A, 4'h1, 4'h1);
        req(1'b0, 20'h0BBBB, 1, 0);
        push(1'b0, 20'h2468A, 4'h1, 4'h1);
        req(1'b0, 20'h0BBBB, 0, 1);

        // Not-present PD: faulting result passed through, flags zero.
        w_phys = 20'h00000; w_pd = 4'h0; w_pt = 4'h0;
        push(1'b1, 20'h00000, 4'h0, 4'h0);
        req(1'b1, 20'h0CCCC, 1, 0);
        @(negedge clk);
        chk("fault_hold", 32'(fault), 32'd1);

        // Reset in the middle of a walk; the abandoned request gets no response.
        w_lat = 8;
        w_phys = 20'h77777; w_pd = 4'h1; w_pt = 4'h1;
        @(negedge clk);
        r0 = resp_cnt;
        itlb_valid = 1'b1; itlb_addr = 20'h0DDDD;
        busy_seen = 0;
        for (int k = 0; k < 50 && !busy_seen; k++) begin
            @(negedge clk); #1;
            if (!ready) busy_seen = 1;
        end
        chk("walk_started", 32'(busy_seen), 32'd1);
        @(negedge clk); rst_n = 1'b0; itlb_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        chk("abort_phys_reset", 32'(phys), 32'd0);
        chk("abort_re_low", 32'(re), 32'd0);
        push(1'b1, 20'h77777, 4'h1, 4'h1);
        req(1'b1, 20'h0EEEE, 1, 0);
        chk("abort_resp_count", 32'(resp_cnt - r0), 32'd1);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog");
    end

endmodule
